// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx_165b serializer.
package piso_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default number of data bits per frame
    localparam int PISO_WIDTH_DEF = 8;

    // Level driven on ser_out whenever no data or parity bit is on the line
    localparam logic PISO_IDLE_LVL = 1'b1;

endpackage

// File: rtl/piso_tx_165b_bit_cnt.sv
// bit_cnt: loadable down-counter with a zero flag.
// Decrement saturates at zero, so the count simply holds 0 once a frame ends.
module bit_cnt #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] r_cnt;

    // Load has priority over decrement; decrement never wraps below zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/piso_tx_165b.sv
// piso_tx_165b: parallel-in serial-out transmitter, MSB first, idle level 1.
// Optional feature macro: PISO_TX_PARITY_EN appends one even-parity bit
// (XOR of the captured word) between the last data bit and the done pulse.
//
// state | meaning
// IDLE  | waiting for start; ready=1, line idle
// SHIFT | one data bit per cycle from shreg MSB
// PAR   | even parity bit on the line (parity build only)
// DONE  | one-cycle done pulse, line idle
module piso_tx_165b
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    output logic             ready,
    output logic             busy,
    output logic             ser_out,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic             r_ready;
    logic             r_busy;
    logic             r_ser;
    logic             r_done;

    logic             w_accept;
    logic             w_dec;
    logic             w_zero;
    logic [WIDTH-1:0] w_shnext;

    // A start is only honoured in IDLE; an unknown start falls to the hold branch
    assign w_accept = (r_state == IDLE) && start;
    assign w_dec    = (r_state == SHIFT);
    // Shift left with 1s filling in, so the register drains to the idle level
    assign w_shnext = (r_shreg << 1) | WIDTH'(1);

    bit_cnt #(
        .CW(CW)
    ) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_accept),
        .dec      (w_dec),
        .load_val (CNT_LOAD),
        .zero     (w_zero)
    );

`ifdef PISO_TX_PARITY_EN
    logic r_par;

    // Parity is taken from the word as captured, never from later d values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= ^d;
        end
    end
`endif

    // Frame FSM with registered outputs computed for the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= '1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_ser   <= PISO_IDLE_LVL;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SHIFT;
                        r_shreg <= d;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_ser   <= d[WIDTH-1];
                    end
                end
                SHIFT: begin
                    r_shreg <= w_shnext;
                    if (w_zero) begin
`ifdef PISO_TX_PARITY_EN
                        r_state <= PAR;
                        r_ser   <= r_par;
`else
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_ser   <= PISO_IDLE_LVL;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_ser <= w_shnext[WIDTH-1];
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PAR: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_ser   <= PISO_IDLE_LVL;
                    r_done  <= 1'b1;
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_shreg <= '1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ser   <= PISO_IDLE_LVL;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = r_ready;
    assign busy    = r_busy;
    assign ser_out = r_ser;
    assign done    = r_done;

endmodule

// File: tb/tb_piso_tx_165b.sv
// Self-checking bench for piso_tx_165b. Expected line states are
// {ready, busy, ser_out, done}, queued as each frame is launched and
// compared one per clock on the falling edge.
module tb_piso_tx_165b;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] d     = '0;
    logic         ready;
    logic         busy;
    logic         ser_out;
    logic         done;

    piso_tx_165b #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .d       (d),
        .ready   (ready),
        .busy    (busy),
        .ser_out (ser_out),
        .done    (done)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] EXP_IDLE = 4'b1010;
    localparam logic [3:0] EXP_DONE = 4'b0011;

    typedef struct {
        logic [3:0] v;
        string      tag;
    } exp_t;

    typedef struct {
        logic [W-1:0] d;
        logic         par;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {rdy,busy,ser,done}=%b expected %b at %0t", tag, act, exp, $time);
    endtask

    task automatic push(input logic [3:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Data bits MSB first, optional parity bit, done pulse, one idle cycle
    task automatic push_frame(input logic [W-1:0] dv, input logic pv);
        for (int i = W - 1; i >= 0; i--)
            push({1'b0, 1'b1, dv[i], 1'b0}, $sformatf("d=%h bit%0d", dv, i));
`ifdef PISO_TX_PARITY_EN
        push({1'b0, 1'b1, pv, 1'b0}, $sformatf("d=%h parity", dv));
        push(EXP_DONE, $sformatf("d=%h done", dv));
`else
        push(EXP_DONE, $sformatf("d=%h done (par %b unused)", dv, pv));
`endif
        push(EXP_IDLE, $sformatf("d=%h idle", dv));
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            check(e.tag, {ready, busy, ser_out, done}, e.v);
        end
    endtask

    // Called at a falling edge with the DUT idle; d is scrambled after acceptance
    task automatic send(input logic [W-1:0] dv, input logic pv);
        check("ready_before_start", {ready, busy, ser_out, done}, EXP_IDLE);
        start = 1'b1;
        d     = dv;
        push_frame(dv, pv);
        @(posedge clk);
        #1;
        start = 1'b0;
        d     = ~dv;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'hC3, 1'b0};
        vecs[4] = '{8'h01, 1'b1};
        vecs[5] = '{8'h80, 1'b1};

        #12;
        check("reset_hold", {ready, busy, ser_out, done}, EXP_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", {ready, busy, ser_out, done}, EXP_IDLE);

        for (int i = 0; i < 6; i++) send(vecs[i].d, vecs[i].par);

        // start held with d=FF during a 00 frame, then exactly one FF frame
        start = 1'b1;
        d     = 8'h00;
        push_frame(8'h00, 1'b0);
        @(posedge clk);
        #1;
        d = 8'hFF;
        drain();
        push_frame(8'hFF, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        push(EXP_IDLE, "no_extra_frame_a");
        push(EXP_IDLE, "no_extra_frame_b");
        drain();

        // Back-to-back 55 then AA with start held high throughout
        start = 1'b1;
        d     = 8'h55;
        push_frame(8'h55, 1'b0);
        @(posedge clk);
        #1;
        d = 8'hAA;
        drain();
        push_frame(8'hAA, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // Asynchronous reset in cycle 4 of a 3C frame
        start = 1'b1;
        d     = 8'h3C;
        @(posedge clk);
        #1;
        start = 1'b0;
        push(4'b0100, "3C bit7");
        push(4'b0100, "3C bit6");
        push(4'b0110, "3C bit5");
        drain();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_midcycle", {ready, busy, ser_out, done}, EXP_IDLE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_in_reset", {ready, busy, ser_out, done}, EXP_IDLE);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_abort", {ready, busy, ser_out, done}, EXP_IDLE);
        send(8'h81, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_tx_165b.md
PISO_TX_165B -- requirements
Module: piso_tx_165b

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits shifted per frame.
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to load d and begin a frame; sampled on rising clk.
REQ-005 Port: d  input  WIDTH  parallel data; captured only on an accepted start.
REQ-006 Port: ready  output  1  high when a start will be accepted this cycle.
REQ-007 Port: busy  output  1  high while a frame is being shifted out.
REQ-008 Port: ser_out  output  1  serial data, MSB first, idle level 1 (74xx165 QH equivalent).
REQ-009 Port: done  output  1  single-cycle pulse after the last bit of a frame.

Function
REQ-010 States: IDLE, SHIFT, PAR (parity build only), DONE; all registered.
REQ-011 IDLE: ready=1, busy=0, ser_out=1, done=0.
REQ-012 start=1 in IDLE is accepted: the shift register loads d and the bit counter loads WIDTH-1; next cycle state=SHIFT.
REQ-013 SHIFT: ser_out=shreg[WIDTH-1]; each clk shifts left one place (fill 1) and decrements the counter; ready=0, busy=1.
REQ-014 d[WIDTH-1] appears on ser_out in the first cycle after acceptance; d[0] appears in cycle WIDTH; each bit is held exactly one cycle.
REQ-015 At counter==0 in SHIFT, the next state is PAR if parity is built, else DONE.
REQ-016 DONE lasts one cycle: done=1, busy=0, ready=0, ser_out=1; then IDLE.
REQ-017 A frame takes WIDTH+1 cycles (WIDTH+2 with parity) from acceptance to the done pulse; back-to-back start is accepted on the first IDLE cycle after DONE.
REQ-018 start while not in IDLE is ignored; d changes after acceptance have no effect on the frame in flight.
REQ-019 X/Z on start is treated as 0 for state transitions; d bits are passed through unmodified, X included.
REQ-020 The counter width is clog2(WIDTH); no wrap-around is reachable; the counter holds at 0 outside SHIFT.

Reset
REQ-021 rst_n=0 forces IDLE immediately, without waiting for clk: shreg all 1s, counter 0, ready=1, busy=0, ser_out=1, done=0.
REQ-022 Reset mid-frame aborts the frame with no done pulse; the first start after release begins a fresh frame.
REQ-023 Reset release is synchronous in effect: the first transition occurs on the first rising clk with rst_n=1.

Configuration
REQ-024 Macro PISO_TX_PARITY_EN: when defined, the PAR state drives ser_out=even parity (XOR of the captured d) for one cycle between the last data bit and DONE.
REQ-025 When PISO_TX_PARITY_EN is undefined, PAR and the parity register are absent; SHIFT goes directly to DONE.

Structure
REQ-026 The shared package piso_pkg holds the state enum typedef (IDLE, SHIFT, PAR, DONE), the default WIDTH constant, and the idle-level constant (1).
REQ-027 One sub-module, bit_cnt (load/decrement down-counter with a zero flag), is instantiated for the bit count; the FSM and shift register stay in piso_tx_165b.

Verification
REQ-028 Reset: rst_n=0 asynchronously mid-cycle -> ready=1, busy=0, ser_out=1, done=0 before the next clk edge.
REQ-029 Basic frame, no parity: d=8'hA5, start pulse -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8, done=1 on cycle 9, ready=1 on cycle 10.
REQ-030 Parity build: d=8'h07 -> eight data bits, then ser_out=1 (odd count of ones) on cycle 9, done on cycle 10; d=8'h03 -> parity bit 0.
REQ-031 Ignore while busy: start=1 held with d=8'hFF during an 8'h00 frame -> all eight bits are 0, and a single new frame begins after DONE.
REQ-032 Reset mid-frame: rst_n low at cycle 4 of an 8'h3C frame -> no done pulse, ser_out=1; a later start with 8'h81 -> clean frame 1,0,0,0,0,0,0,1.
REQ-033 Back-to-back: start held high continuously with 8'h55 then 8'hAA -> two frames separated by exactly one DONE cycle and one IDLE cycle.
